// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg -- shared definitions for the SPI SCLK engine.
//   * spi_state_t : engine FSM state encoding (IDLE, RUN, SETUP, HOLD)
//   * spi_mode_t  : latched clock mode (cpol, cpha)
//   * default widths for the half-period divider and the SCLK-cycle count
//   * helpers that classify an SCLK edge as a sample or shift strobe
// SETUP and HOLD are only entered when SPI_SCLK_CS_DELAY_EN is defined.
// -----------------------------------------------------------------------------
package spi_pkg;

    localparam int SPI_DIV_W_DEF = 16;
    localparam int SPI_CNT_W_DEF = 7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_SETUP = 2'd2,
        ST_HOLD  = 2'd3
    } spi_state_t;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

    // A leading edge leaves the idle level; cpha picks which edge captures.
    function automatic logic is_sample_edge(input spi_mode_t mode, input logic leading);
        return mode.cpha ? ~leading : leading;
    endfunction

    // cpha=0 launches on trailing edges except the final one (nothing left to launch).
    function automatic logic is_shift_edge(input spi_mode_t mode, input logic leading,
                                           input logic last);
        return mode.cpha ? leading : (~leading & ~last);
    endfunction

endpackage

// File: rtl/spi_sclk_engine_if.sv
// -----------------------------------------------------------------------------
// spi_sclk_engine_if -- control/strobe bundle of the SPI SCLK engine.
//   master : drives enable, go, cpol, cpha, divider, nclk; observes the rest
//   slave  : the engine itself
// Outputs: sclk, pos_edge, neg_edge, sample, shift, busy, done
//          (+ cs_n when SPI_SCLK_CS_DELAY_EN is defined).
// -----------------------------------------------------------------------------
interface spi_sclk_engine_if
    import spi_pkg::*;
#(
    parameter int DIV_W = SPI_DIV_W_DEF,
    parameter int CNT_W = SPI_CNT_W_DEF
);
    logic             enable;
    logic             go;
    logic             cpol;
    logic             cpha;
    logic [DIV_W-1:0] divider;
    logic [CNT_W-1:0] nclk;
    logic             sclk;
    logic             pos_edge;
    logic             neg_edge;
    logic             sample;
    logic             shift;
    logic             busy;
    logic             done;
`ifdef SPI_SCLK_CS_DELAY_EN
    logic             cs_n;
`endif

    modport master (
        output enable, go, cpol, cpha, divider, nclk,
        input  sclk, pos_edge, neg_edge, sample, shift, busy, done
`ifdef SPI_SCLK_CS_DELAY_EN
        , input cs_n
`endif
    );

    modport slave (
        input  enable, go, cpol, cpha, divider, nclk,
        output sclk, pos_edge, neg_edge, sample, shift, busy, done
`ifdef SPI_SCLK_CS_DELAY_EN
        , output cs_n
`endif
    );
endinterface

// File: rtl/spi_halfper_cnt.sv
// -----------------------------------------------------------------------------
// spi_halfper_cnt -- SCLK half-period down-counter.
//   clk_in, rst : clock, asynchronous active-high reset
//   load        : load load_val (has priority over decrement)
//   load_val    : value to load (divider = half-period minus one)
//   zero        : counter is at zero (half-period elapsed)
// The counter parks at zero instead of wrapping.
// -----------------------------------------------------------------------------
module spi_halfper_cnt #(
    parameter int DIV_W = 16
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             load,
    input  logic [DIV_W-1:0] load_val,
    output logic             zero
);
    logic [DIV_W-1:0] cnt_r;

    // Load / decrement the half-period count.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (load) begin
            cnt_r <= load_val;
        end else if (cnt_r != '0) begin
            cnt_r <= cnt_r - {{(DIV_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign zero = (cnt_r == '0);
endmodule

// File: rtl/spi_sclk_engine.sv
// -----------------------------------------------------------------------------
// spi_sclk_engine -- SPI serial-clock generator with shift/sample strobes.
//   clk_in : system clock (rising edge)
//   rst    : asynchronous active-high reset
//   bus    : spi_sclk_engine_if.slave (enable, go, cpol, cpha, divider, nclk in;
//            sclk, pos_edge, neg_edge, sample, shift, busy, done out)
// Optional macro SPI_SCLK_CS_DELAY_EN adds cs_n and the SETUP/HOLD states that
// give one half-period of chip-select lead and lag around the SCLK burst.
// All outputs are registered. In IDLE, sclk follows the cpol input.
// -----------------------------------------------------------------------------
module spi_sclk_engine
    import spi_pkg::*;
#(
    parameter int DIV_W = SPI_DIV_W_DEF,
    parameter int CNT_W = SPI_CNT_W_DEF
) (
    input  logic                 clk_in,
    input  logic                 rst,
    spi_sclk_engine_if.slave     bus
);
    spi_state_t       state_r, state_s;
    spi_mode_t        mode_r, mode_s;
    logic [DIV_W-1:0] div_r, div_s;
    logic [CNT_W:0]   edges_r, edges_s;     // edges still to produce, minus one
    logic             sclk_r, sclk_s;
    logic             pos_r, pos_s, neg_r, neg_s;
    logic             sample_r, sample_s, shift_r, shift_s;
    logic             busy_r, busy_s, done_r, done_s;
`ifdef SPI_SCLK_CS_DELAY_EN
    logic             cs_n_r, cs_n_s;
`endif
    logic             hp_load_s;
    logic [DIV_W-1:0] hp_val_s;
    logic             hp_zero_s;
    logic             leading_s;
    logic             last_s;

    spi_halfper_cnt #(.DIV_W(DIV_W)) u_halfper (
        .clk_in   (clk_in),
        .rst      (rst),
        .load     (hp_load_s),
        .load_val (hp_val_s),
        .zero     (hp_zero_s)
    );

    assign leading_s = (sclk_r == mode_r.cpol);
    assign last_s    = (edges_r == '0);

    // Next-state and next-output logic.
    always_comb begin
        state_s   = state_r;
        mode_s    = mode_r;
        div_s     = div_r;
        edges_s   = edges_r;
        sclk_s    = sclk_r;
        pos_s     = 1'b0;
        neg_s     = 1'b0;
        sample_s  = 1'b0;
        shift_s   = 1'b0;
        busy_s    = busy_r;
        done_s    = 1'b0;
        hp_load_s = 1'b0;
        hp_val_s  = div_r;
`ifdef SPI_SCLK_CS_DELAY_EN
        cs_n_s    = cs_n_r;
`endif
        case (state_r)
            ST_IDLE: begin
                sclk_s = bus.cpol;
                busy_s = 1'b0;
                if (bus.go && bus.enable) begin
                    mode_s    = '{cpol: bus.cpol, cpha: bus.cpha};
                    div_s     = bus.divider;
                    // nclk=0 wraps to all-ones, i.e. 2*2^CNT_W edges.
                    edges_s   = {bus.nclk, 1'b0} - {{CNT_W{1'b0}}, 1'b1};
                    hp_load_s = 1'b1;
                    hp_val_s  = bus.divider;
                    busy_s    = 1'b1;
`ifdef SPI_SCLK_CS_DELAY_EN
                    state_s   = ST_SETUP;
                    cs_n_s    = 1'b0;
`else
                    state_s   = ST_RUN;
`endif
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (hp_zero_s) begin
                    hp_load_s = 1'b1;
                    sclk_s    = ~sclk_r;
                    pos_s     = ~sclk_r;
                    neg_s     = sclk_r;
                    sample_s  = is_sample_edge(mode_r, leading_s);
                    shift_s   = is_shift_edge(mode_r, leading_s, last_s);
                    edges_s   = edges_r - {{CNT_W{1'b0}}, 1'b1};
                    if (last_s) begin
`ifdef SPI_SCLK_CS_DELAY_EN
                        state_s = ST_HOLD;
`else
                        state_s = ST_IDLE;
                        busy_s  = 1'b0;
                        done_s  = 1'b1;
`endif
                    end else begin
                        state_s = ST_RUN;
                    end
                end else begin
                    state_s = ST_RUN;
                end
            end
`ifdef SPI_SCLK_CS_DELAY_EN
            ST_SETUP: begin
                if (hp_zero_s) begin
                    state_s   = ST_RUN;
                    hp_load_s = 1'b1;
                end else begin
                    state_s = ST_SETUP;
                end
            end
            ST_HOLD: begin
                if (hp_zero_s) begin
                    state_s = ST_IDLE;
                    busy_s  = 1'b0;
                    done_s  = 1'b1;
                    cs_n_s  = 1'b1;
                end else begin
                    state_s = ST_HOLD;
                end
            end
`endif
            default: begin
                state_s = ST_IDLE;
                busy_s  = 1'b0;
            end
        endcase

        // Abort: enable low outside IDLE drops the transfer without done.
        if (!bus.enable && (state_r != ST_IDLE)) begin
            state_s   = ST_IDLE;
            sclk_s    = mode_r.cpol;
            pos_s     = 1'b0;
            neg_s     = 1'b0;
            sample_s  = 1'b0;
            shift_s   = 1'b0;
            busy_s    = 1'b0;
            done_s    = 1'b0;
            hp_load_s = 1'b0;
`ifdef SPI_SCLK_CS_DELAY_EN
            cs_n_s    = 1'b1;
`endif
        end else begin
            state_s = state_s;
        end
    end

    // FSM state register.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Latched transfer configuration, edge counter and registered outputs.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            mode_r   <= '0;
            div_r    <= '0;
            edges_r  <= '1;
            sclk_r   <= 1'b0;
            pos_r    <= 1'b0;
            neg_r    <= 1'b0;
            sample_r <= 1'b0;
            shift_r  <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
`ifdef SPI_SCLK_CS_DELAY_EN
            cs_n_r   <= 1'b1;
`endif
        end else begin
            mode_r   <= mode_s;
            div_r    <= div_s;
            edges_r  <= edges_s;
            sclk_r   <= sclk_s;
            pos_r    <= pos_s;
            neg_r    <= neg_s;
            sample_r <= sample_s;
            shift_r  <= shift_s;
            busy_r   <= busy_s;
            done_r   <= done_s;
`ifdef SPI_SCLK_CS_DELAY_EN
            cs_n_r   <= cs_n_s;
`endif
        end
    end

    assign bus.sclk     = sclk_r;
    assign bus.pos_edge = pos_r;
    assign bus.neg_edge = neg_r;
    assign bus.sample   = sample_r;
    assign bus.shift    = shift_r;
    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
`ifdef SPI_SCLK_CS_DELAY_EN
    assign bus.cs_n     = cs_n_r;
`endif
endmodule

// File: tb/tb_spi_sclk_engine.sv
// -----------------------------------------------------------------------------
// tb_spi_sclk_engine -- self-checking bench for spi_sclk_engine.
// Expected outputs come from a cycle-offset model: edge k of a transfer lands
// k half-periods after busy rises (plus one half-period of SETUP when
// SPI_SCLK_CS_DELAY_EN is defined); odd edges are leading edges.
// -----------------------------------------------------------------------------
module tb_spi_sclk_engine;
    localparam int DIV_W = 16;
    localparam int CNT_W = 7;

    logic clk_in = 1'b0;
    logic rst    = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    spi_sclk_engine_if #(.DIV_W(DIV_W), .CNT_W(CNT_W)) bus ();

    spi_sclk_engine #(.DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
        .clk_in (clk_in),
        .rst    (rst),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    // Observed outputs: {sclk, pos_edge, neg_edge, sample, shift, busy, done}.
    function automatic logic [6:0] obs();
        return {bus.sclk, bus.pos_edge, bus.neg_edge, bus.sample, bus.shift, bus.busy, bus.done};
    endfunction

    function automatic int pre_of(int dv);
`ifdef SPI_SCLK_CS_DELAY_EN
        return dv + 1;
`else
        return 0;
`endif
    endfunction

    // Offset (from busy rising) of the cycle in which busy is low and done high.
    function automatic int fin_of(int dv, int nc);
        int n2;
        n2 = 2 * ((nc == 0) ? (1 << CNT_W) : nc);
`ifdef SPI_SCLK_CS_DELAY_EN
        return pre_of(dv) + (n2 + 1) * (dv + 1);
`else
        return n2 * (dv + 1);
`endif
    endfunction

    // Reference: expected outputs at a cycle offset from busy rising.
    function automatic logic [6:0] model(int off, bit cp, bit ch, int dv, int nc);
        int hp, n2, rel, k, fin;
        logic lvl, edge_now, lead, smp, shf;
        hp  = dv + 1;
        n2  = 2 * ((nc == 0) ? (1 << CNT_W) : nc);
        fin = fin_of(dv, nc);
        rel = off - pre_of(dv);
        k   = (rel < 0) ? 0 : rel / hp;
        if (k > n2) k = n2;
        edge_now = (rel > 0) && (rel % hp == 0) && (rel / hp <= n2);
        lvl  = cp ^ k[0];
        lead = k[0];
        smp  = edge_now && (ch ? !lead : lead);
        shf  = edge_now && (ch ? lead : (!lead && (k != n2)));
        return {lvl, edge_now && lvl, edge_now && !lvl, smp, shf, off < fin, off == fin};
    endfunction

    // Present a configuration with go for one cycle; returns at the negedge of
    // the first busy cycle.
    task automatic kick(bit cp, bit ch, int dv, int nc);
        @(negedge clk_in);
        bus.cpol    = cp;
        bus.cpha    = ch;
        bus.divider = dv[DIV_W-1:0];
        bus.nclk    = nc[CNT_W-1:0];
        bus.go      = 1'b1;
        @(negedge clk_in);
        bus.go      = 1'b0;
    endtask

    task automatic test_reset();
        logic [6:0] g;
        bus.enable = 1'b1; bus.go = 1'b0; bus.cpol = 1'b1; bus.cpha = 1'b0;
        bus.divider = '0; bus.nclk = 8'd0;
        #1 rst = 1'b1;
        @(negedge clk_in);
        g = obs();
        checks++;
        if (g !== 7'b0) begin
            failures++; $display("FAIL reset_state got=%b exp=%b", g, 7'b0);
        end
`ifdef SPI_SCLK_CS_DELAY_EN
        checks++;
        if (bus.cs_n !== 1'b1) begin
            failures++; $display("FAIL reset_cs_n got=%b exp=1", bus.cs_n);
        end
`endif
        rst = 1'b0;
        @(negedge clk_in);
        g = obs();
        checks++;
        if (g !== 7'b1000000) begin
            failures++; $display("FAIL idle_follows_cpol got=%b exp=%b", g, 7'b1000000);
        end
    endtask

    task automatic test_mode00();
        logic [6:0] g, e;
        int n_smp = 0, n_shf = 0, n_pos = 0, n_done = 0, fin;
        fin = fin_of(0, 8);
        kick(1'b0, 1'b0, 0, 8);
        for (int off = 0; off <= fin; off++) begin
            if (off > 0) @(negedge clk_in);
            g = obs(); e = model(off, 1'b0, 1'b0, 0, 8);
            checks++;
            if (g !== e) begin
                failures++; $display("FAIL mode00 off=%0d got=%b exp=%b", off, g, e);
            end
            n_pos += int'(g[5]); n_smp += int'(g[3]); n_shf += int'(g[2]); n_done += int'(g[0]);
        end
        checks++;
        if (n_pos != 8 || n_smp != 8 || n_shf != 7 || n_done != 1) begin
            failures++;
            $display("FAIL mode00_counts got pos=%0d smp=%0d shf=%0d done=%0d exp 8/8/7/1",
                     n_pos, n_smp, n_shf, n_done);
        end
    endtask

    task automatic test_mode11();
        logic [6:0] g, e;
        int fin;
        fin = fin_of(3, 2);
        kick(1'b1, 1'b1, 3, 2);
        for (int off = 0; off <= fin; off++) begin
            if (off > 0) @(negedge clk_in);
            g = obs(); e = model(off, 1'b1, 1'b1, 3, 2);
            checks++;
            if (g !== e) begin
                failures++; $display("FAIL mode11 off=%0d got=%b exp=%b", off, g, e);
            end
        end
    endtask

    task automatic test_random();
        logic [6:0] g, e;
        bit cp, ch;
        int dv, nc, fin;
        for (int t = 0; t < 8; t++) begin
            cp = 1'($urandom_range(0, 1)); ch = 1'($urandom_range(0, 1));
            dv = $urandom_range(0, 3);     nc = $urandom_range(1, 5);
            fin = fin_of(dv, nc);
            kick(cp, ch, dv, nc);
            for (int off = 0; off <= fin; off++) begin
                if (off > 0) @(negedge clk_in);
                g = obs(); e = model(off, cp, ch, dv, nc);
                checks++;
                if (g !== e) begin
                    failures++;
                    $display("FAIL random t=%0d off=%0d got=%b exp=%b", t, off, g, e);
                end
                if (off == 1) begin
                    bus.cpol = ~cp; bus.cpha = ~ch;
                    bus.divider = DIV_W'($urandom_range(0, 9));
                    bus.nclk = CNT_W'($urandom_range(1, 9));
                end
            end
        end
    endtask

    task automatic test_nclk_zero();
        logic [6:0] g, e;
        int fin, n_pos = 0;
        fin = fin_of(0, 0);
        kick(1'b0, 1'b0, 0, 0);
        for (int off = 0; off <= fin; off++) begin
            if (off > 0) @(negedge clk_in);
            g = obs(); e = model(off, 1'b0, 1'b0, 0, 0);
            checks++;
            if (g !== e) begin
                failures++; $display("FAIL nclk_zero off=%0d got=%b exp=%b", off, g, e);
            end
            n_pos += int'(g[5]);
        end
        checks++;
        if (n_pos != 128) begin
            failures++; $display("FAIL nclk_zero_periods got=%0d exp=128", n_pos);
        end
    endtask

    task automatic test_abort();
        logic [6:0] g, e;
        int ab;
        ab = pre_of(2) + 3 * 3;
        kick(1'b1, 1'b0, 2, 4);
        for (int off = 0; off <= ab; off++) begin
            if (off > 0) @(negedge clk_in);
            g = obs(); e = model(off, 1'b1, 1'b0, 2, 4);
            checks++;
            if (g !== e) begin
                failures++; $display("FAIL abort_pre off=%0d got=%b exp=%b", off, g, e);
            end
        end
        bus.enable = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk_in);
            if (c == 3) bus.enable = 1'b1;
            g = obs();
            checks++;
            if (g !== 7'b1000000) begin
                failures++; $display("FAIL abort c=%0d got=%b exp=%b", c, g, 7'b1000000);
            end
`ifdef SPI_SCLK_CS_DELAY_EN
            checks++;
            if (bus.cs_n !== 1'b1) begin
                failures++; $display("FAIL abort_cs_n c=%0d got=%b exp=1", c, bus.cs_n);
            end
`endif
        end
        // go coinciding with enable low in IDLE must not start a transfer.
        bus.go = 1'b1; bus.enable = 1'b0;
        @(negedge clk_in);
        bus.go = 1'b0; bus.enable = 1'b1;
        for (int c = 0; c < 3; c++) begin
            g = obs();
            checks++;
            if (g !== 7'b1000000) begin
                failures++; $display("FAIL go_enable_drop c=%0d got=%b exp=%b", c, g, 7'b1000000);
            end
            @(negedge clk_in);
        end
    endtask

    task automatic test_reset_mid();
        logic [6:0] g;
        kick(1'b0, 1'b1, 1, 4);
        repeat (5) @(negedge clk_in);
        #2 rst = 1'b1;
        #1 g = obs();
        checks++;
        if (g !== 7'b0) begin
            failures++; $display("FAIL reset_mid got=%b exp=%b", g, 7'b0);
        end
        @(negedge clk_in);
        rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk_in);
            g = obs();
            checks++;
            if (g !== 7'b0) begin
                failures++; $display("FAIL reset_mid_after c=%0d got=%b exp=%b", c, g, 7'b0);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] g, e;
        int fin1, fin2;
        fin1 = fin_of(1, 3);
        fin2 = fin_of(0, 2);
        kick(1'b0, 1'b1, 1, 3);
        for (int off = 0; off <= fin1 + 1; off++) begin
            if (off > 0) @(negedge clk_in);
            g = obs();
            e = (off <= fin1) ? model(off, 1'b0, 1'b1, 1, 3) : 7'b0000000;
            checks++;
            if (g !== e) begin
                failures++; $display("FAIL b2b_first off=%0d got=%b exp=%b", off, g, e);
            end
            if (off == 2) bus.go = 1'b1;
            if (off == 3) bus.go = 1'b0;
            if (off == 4) bus.divider = 16'd7;
        end
        bus.cpol = 1'b1; bus.cpha = 1'b0; bus.divider = 16'd0; bus.nclk = 7'd2;
        bus.go = 1'b1;
        @(negedge clk_in);
        bus.go = 1'b0;
        for (int off = 0; off <= fin2; off++) begin
            if (off > 0) @(negedge clk_in);
            g = obs(); e = model(off, 1'b1, 1'b0, 0, 2);
            checks++;
            if (g !== e) begin
                failures++; $display("FAIL b2b_second off=%0d got=%b exp=%b", off, g, e);
            end
        end
    endtask

`ifdef SPI_SCLK_CS_DELAY_EN
    task automatic test_cs_delay();
        logic [6:0] g, e;
        int fin;
        fin = fin_of(1, 2);
        kick(1'b0, 1'b0, 1, 2);
        for (int off = 0; off <= fin; off++) begin
            if (off > 0) @(negedge clk_in);
            g = obs(); e = model(off, 1'b0, 1'b0, 1, 2);
            checks++;
            if (g !== e || bus.cs_n !== (off >= fin)) begin
                failures++;
                $display("FAIL cs_delay off=%0d got=%b/%b exp=%b/%b", off, g, bus.cs_n, e, off >= fin);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_mode00();
        test_mode11();
        test_random();
        test_nclk_zero();
        test_abort();
        test_reset_mid();
        test_back_to_back();
`ifdef SPI_SCLK_CS_DELAY_EN
        test_cs_delay();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
